// File: rtl/switch_allocator_pkg.sv
// Shared router types: port encoding and flit labels used by the allocator
// and the rest of the mesh router.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = $clog2(PORT_NUM);

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Per-output round-robin arbiter with wormhole lock: free outputs arbitrate
// among head flits, locked outputs serve only their owner's body/tail flits.
module rr_arbiter #(
  parameter int PORT_NUM  = 5,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PORT_NUM-1:0]  req,
  input  logic [PORT_NUM-1:0]  head_q,
  input  logic [PORT_NUM-1:0]  tail_q,
  input  logic                 ready,
  output logic [PORT_NUM-1:0]  grant,
  output logic                 valid,
  output logic [PORT_SIZE-1:0] idx
);

  typedef enum logic {FREE, LOCKED} lock_t;

  lock_t                lock_q, lock_d;
  logic [PORT_SIZE-1:0] owner_q, owner_d;
  logic [PORT_SIZE-1:0] ptr_q, ptr_d;
  logic [PORT_SIZE-1:0] win;
  logic [PORT_SIZE-1:0] cand;
  logic                 found;
  int                   j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= FREE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    j       = 0;
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    if (lock_q == FREE) begin
      // Scan starting at ptr, wrapping, and keep the first head candidate.
      for (int k = 0; k < PORT_NUM; k++) begin
        j = int'(ptr_q) + k;
        if (j >= PORT_NUM) j = j - PORT_NUM;
        cand = PORT_SIZE'(j);
        if (!found && req[cand] && head_q[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end else if (req[owner_q] && !head_q[owner_q]) begin
      found = 1'b1;
      win   = owner_q;
    end

    // Outputs are held low during reset even though state is already cleared.
    valid = found && ready && rst_n;
    idx   = valid ? win : '0;
    grant = '0;
    if (valid) grant[win] = 1'b1;

    if (valid) begin
      if (lock_q == FREE) begin
        ptr_d = (win == PORT_SIZE'(PORT_NUM - 1)) ? '0 : win + 1'b1;
        if (!tail_q[win]) begin
          lock_d  = LOCKED;
          owner_d = win;
        end
      end else if (tail_q[win]) begin
        lock_d = FREE;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: decodes per-(input, output) requests, runs one wormhole
// round-robin arbiter per output and drives crossbar selects and input grants.
module switch_allocator
  import noc_params::*;
#(
  parameter int PORT_NUM  = noc_params::PORT_NUM,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic        [PORT_NUM-1:0]          request_i,
  input  port_t       [PORT_NUM-1:0]          out_port_i,
  input  flit_label_t [PORT_NUM-1:0]          flit_label_i,
  input  logic        [PORT_NUM-1:0]          downstream_ready_i,
  output logic        [PORT_NUM-1:0]          grant_o,
  output logic        [PORT_NUM-1:0]          out_valid_o,
  output logic        [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o
);

  logic [PORT_NUM-1:0]                head_q;
  logic [PORT_NUM-1:0]                tail_q;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  req_mat;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  gnt_mat;

  // HEAD/HEADTAIL open a packet; TAIL/HEADTAIL close one.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      head_q[i] = (flit_label_i[i] == HEAD) || (flit_label_i[i] == HEADTAIL);
      tail_q[i] = (flit_label_i[i] == TAIL) || (flit_label_i[i] == HEADTAIL);
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
      assign req_mat[o][i] = request_i[i] &&
                             (out_port_i[i] == PORT_SIZE'(o));
    end

    rr_arbiter #(
      .PORT_NUM  (PORT_NUM),
      .PORT_SIZE (PORT_SIZE)
    ) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_mat[o]),
      .head_q (head_q),
      .tail_q (tail_q),
      .ready  (downstream_ready_i[o]),
      .grant  (gnt_mat[o]),
      .valid  (out_valid_o[o]),
      .idx    (xbar_sel_o[o])
    );
  end

  always_comb begin
    grant_o = '0;
    for (int o = 0; o < PORT_NUM; o++) grant_o = grant_o | gnt_mat[o];
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, round robin, wormhole lock,
// backpressure, parallel grants and reset in the middle of a packet.
module tb_switch_allocator;
  import noc_params::*;

  logic                    clk;
  logic                    rst_n;
  logic        [4:0]       request;
  port_t       [4:0]       out_port;
  flit_label_t [4:0]       label;
  logic        [4:0]       ready;
  logic        [4:0]       grant;
  logic        [4:0]       out_valid;
  logic        [4:0][2:0]  xbar_sel;

  int n_checks = 0;
  int n_fails  = 0;

  switch_allocator dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .request_i          (request),
    .out_port_i         (out_port),
    .flit_label_i       (label),
    .downstream_ready_i (ready),
    .grant_o            (grant),
    .out_valid_o        (out_valid),
    .xbar_sel_o         (xbar_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    request  = '0;
    ready    = '1;
    for (int i = 0; i < 5; i++) begin
      out_port[i] = LOCAL;
      label[i]    = HEAD;
    end
  endtask

  task automatic send(input int i, input port_t p, input flit_label_t l);
    request[i]  = 1'b1;
    out_port[i] = p;
    label[i]    = l;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) send(i, EAST, HEAD);
    #2;
    chk("rst_grant", grant, 5'b00000);
    chk("rst_valid", out_valid, 5'b00000);
    chk("rst_xbar", xbar_sel, 15'd0);
    step();
    chk("rst_grant_edge", grant, 5'b00000);
    rst_n = 1'b1;
    #1;
    chk("post_rst_grant", grant, 5'b00001);
    chk("post_rst_xbar4", xbar_sel[4], 3'd0);
    step();
    // LOCAL now owns EAST; close the packet.
    idle();
    send(0, EAST, TAIL);
    #1;
    chk("post_rst_tail", grant, 5'b00001);
    step();

    // Round robin from a clean reset.
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    send(0, EAST, HEADTAIL);
    send(1, EAST, HEADTAIL);
    #1;
    chk("rr0_grant", grant, 5'b00001);
    chk("rr0_xbar", xbar_sel[4], 3'd0);
    step();
    chk("rr1_grant", grant, 5'b00010);
    chk("rr1_xbar", xbar_sel[4], 3'd1);
    step();
    chk("rr2_grant", grant, 5'b00001);
    chk("rr2_xbar", xbar_sel[4], 3'd0);
    step();
    chk("rr3_grant", grant, 5'b00010);
    chk("rr3_xbar", xbar_sel[4], 3'd1);
    step();

    // Wormhole lock on SOUTH with backpressure mid-packet.
    idle();
    send(3, SOUTH, HEAD);
    send(4, SOUTH, HEAD);
    #1;
    chk("wh_head_grant", grant, 5'b01000);
    chk("wh_head_xbar", xbar_sel[2], 3'd3);
    step();
    send(3, SOUTH, BODY);
    #1;
    chk("wh_body1_grant", grant, 5'b01000);
    step();
    ready[SOUTH] = 1'b0;
    #1;
    chk("bp0_grant", grant, 5'b00000);
    chk("bp0_valid", out_valid, 5'b00000);
    step();
    chk("bp1_grant", grant, 5'b00000);
    step();
    ready[SOUTH] = 1'b1;
    #1;
    chk("bp_resume_grant", grant, 5'b01000);
    chk("bp_resume_xbar", xbar_sel[2], 3'd3);
    step();
    send(3, SOUTH, TAIL);
    #1;
    chk("wh_tail_grant", grant, 5'b01000);
    step();
    request[3] = 1'b0;
    #1;
    chk("wh_east_grant", grant, 5'b10000);
    chk("wh_east_xbar", xbar_sel[2], 3'd4);
    step();
    send(4, SOUTH, TAIL);
    #1;
    chk("wh_east_tail", grant, 5'b10000);
    step();

    // BODY to a free output is ignored.
    idle();
    send(1, NORTH, BODY);
    #1;
    chk("body_free_grant", grant, 5'b00000);
    step();

    // Parallel: input i -> output 4-i.
    idle();
    send(0, EAST, HEADTAIL);
    send(1, WEST, HEADTAIL);
    send(2, SOUTH, HEADTAIL);
    send(3, NORTH, HEADTAIL);
    send(4, LOCAL, HEADTAIL);
    #1;
    chk("par_grant", grant, 5'b11111);
    chk("par_valid", out_valid, 5'b11111);
    chk("par_xbar", xbar_sel, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    step();

    // Reset while NORTH owns LOCAL.
    idle();
    send(1, LOCAL, HEAD);
    #1;
    chk("mid_head_grant", grant, 5'b00010);
    step();
    send(1, LOCAL, BODY);
    #1;
    chk("mid_body_locked", grant, 5'b00010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 5'b00000);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mid_orphan_body", grant, 5'b00000);
    send(2, LOCAL, HEAD);
    #1;
    chk("mid_new_head", grant, 5'b00100);
    chk("mid_new_xbar", xbar_sel[0], 3'd2);
    step();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
